// File: rtl/dht_poll_scheduler.sv
// DHT11 poll scheduler: paces start pulses to the single-wire engine, enforces the
// sensor re-trigger gap, times out and retries failed transactions, holds the last good reading.
module dht_poll_scheduler #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int POLL_MS   = 2000,
  parameter int GUARD_MS  = 1100,
  parameter int TOUT_MS   = 10,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        req_i,
  output logic        ack_o,
  output logic        start_o,
  input  logic        eng_done_i,
  input  logic        eng_err_i,
  input  logic [39:0] eng_data_i,
  output logic        busy_o,
  output logic [15:0] hum_o,
  output logic [15:0] tmp_o,
  output logic        valid_o,
  output logic        update_o,
  output logic        fail_o,
  output logic [7:0]  err_cnt_o
);

  localparam int DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(POLL_MS + 1) + 1;
  localparam int TW  = $clog2(TOUT_MS + 1) + 1;
  localparam int RW  = $clog2(MAX_RETRY + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_START, S_BUSY, S_CHECK, S_GOOD, S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [SW-1:0]   since_q, since_d;
  logic [TW-1:0]   tout_q, tout_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            pend_q, pend_d;
  logic            first_q, first_d;
  logic            req_sel_q, req_sel_d;
  logic [39:0]     frame_q, frame_d;
  logic [15:0]     hum_q, hum_d;
  logic [15:0]     tmp_q, tmp_d;
  logic            valid_q, valid_d;
  logic            fail_q, fail_d;
  logic [7:0]      err_q, err_d;

  logic            tick;
  logic [SW-1:0]   since_next;
  logic [TW-1:0]   tout_next;
  logic [7:0]      chk_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      since_q   <= '0;
      tout_q    <= '0;
      retry_q   <= '0;
      pend_q    <= 1'b0;
      first_q   <= 1'b1;
      req_sel_q <= 1'b0;
      frame_q   <= '0;
      hum_q     <= '0;
      tmp_q     <= '0;
      valid_q   <= 1'b0;
      fail_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      since_q   <= since_d;
      tout_q    <= tout_d;
      retry_q   <= retry_d;
      pend_q    <= pend_d;
      first_q   <= first_d;
      req_sel_q <= req_sel_d;
      frame_q   <= frame_d;
      hum_q     <= hum_d;
      tmp_q     <= tmp_d;
      valid_q   <= valid_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
    end
  end

  // Decisions look at the count including this cycle's tick so start-to-start is exact.
  always_comb begin
    tick       = (pre_q == PW'(DIV - 1));
    pre_d      = tick ? '0 : pre_q + 1'b1;
    since_next = (since_q >= SW'(POLL_MS)) ? SW'(POLL_MS)
                                           : since_q + {{(SW-1){1'b0}}, tick};
    tout_next  = tout_q + {{(TW-1){1'b0}}, tick};
    chk_sum    = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
  end

  always_comb begin
    state_d   = state_q;
    since_d   = since_next;
    tout_d    = tout_q;
    retry_d   = retry_q;
    pend_d    = pend_q;
    first_d   = first_q;
    req_sel_d = req_sel_q;
    frame_d   = frame_q;
    hum_d     = hum_q;
    tmp_d     = tmp_q;
    valid_d   = valid_q;
    fail_d    = fail_q;
    err_d     = err_q;
    start_o   = 1'b0;
    ack_o     = 1'b0;
    busy_o    = 1'b0;
    update_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (since_next >= SW'(GUARD_MS) &&
                     (req_i || since_next >= SW'(POLL_MS) || pend_q || first_q)) begin
          state_d   = S_START;
          req_sel_d = req_i;
        end
      end
      S_START: begin
        start_o = 1'b1;
        ack_o   = req_sel_q;
        since_d = {{(SW-1){1'b0}}, tick};
        tout_d  = '0;
        pend_d  = 1'b0;
        first_d = 1'b0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        busy_o = 1'b1;
        tout_d = tout_next;
        if (eng_done_i) frame_d = eng_data_i;
        if (eng_err_i || tout_next >= TW'(TOUT_MS)) state_d = S_FAIL;
        else if (eng_done_i)                        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (chk_sum == frame_q[7:0]) begin
          state_d = S_GOOD;
          hum_d   = frame_q[39:24];
          tmp_d   = frame_q[23:8];
          valid_d = 1'b1;
          fail_d  = 1'b0;
          retry_d = '0;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_GOOD: begin
        update_o = 1'b1;
        state_d  = en ? S_WAIT : S_IDLE;
      end
      S_FAIL: begin
        err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
        if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          pend_d  = 1'b1;
        end else begin
          fail_d  = 1'b1;
          retry_d = '0;
          pend_d  = 1'b0;
        end
        state_d = en ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hum_o     = hum_q;
  assign tmp_o     = tmp_q;
  assign valid_o   = valid_q;
  assign fail_o    = fail_q;
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_dht_poll_scheduler.sv
// Directed bench for dht_poll_scheduler with a 1-cycle ms tick.
// Each scenario task resets the DUT, drives a small engine model and checks inline.
module tb_dht_poll_scheduler;

  localparam logic [39:0] GOOD_FRAME = 40'h3700_1A00_51;
  localparam logic [39:0] BAD_FRAME  = 40'h3700_1A00_52;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        req_i = 1'b0;
  logic        ack_o, start_o, busy_o, valid_o, update_o, fail_o;
  logic        eng_done_i = 1'b0;
  logic        eng_err_i = 1'b0;
  logic [39:0] eng_data_i = '0;
  logic [15:0] hum_o, tmp_o;
  logic [7:0]  err_cnt_o;

  int cyc = 0;
  int checks = 0;
  int fails = 0;

  dht_poll_scheduler #(
    .CLK_HZ(1000), .POLL_MS(20), .GUARD_MS(11), .TOUT_MS(5), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req_i(req_i), .ack_o(ack_o), .start_o(start_o),
    .eng_done_i(eng_done_i), .eng_err_i(eng_err_i), .eng_data_i(eng_data_i),
    .busy_o(busy_o), .hum_o(hum_o), .tmp_o(tmp_o), .valid_o(valid_o),
    .update_o(update_o), .fail_o(fail_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset(output int t_rel);
    @(negedge clk);
    rst = 1'b0; en = 1'b0; req_i = 1'b0;
    eng_done_i = 1'b0; eng_err_i = 1'b0; eng_data_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1; en = 1'b1;
    t_rel = cyc;
  endtask

  task automatic wait_start(input int limit, output int t);
    int n = 0;
    t = -1;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (start_o) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++; fails++;
      $display("[TB] FAIL start_timeout: no start_o within %0d cycles", limit);
    end
  endtask

  task automatic engine_reply(input logic d, input logic e, input logic [39:0] f);
    @(negedge clk);
    eng_done_i = d; eng_err_i = e; eng_data_i = f;
    @(negedge clk);
    eng_done_i = 1'b0; eng_err_i = 1'b0; eng_data_i = '0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_o) n++;
      else break;
    end
  endtask

  task automatic test_reset;
    int tr, t1;
    do_reset(tr);
    checks++;
    if ({ack_o, start_o, busy_o, hum_o, tmp_o, valid_o, update_o, fail_o, err_cnt_o} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %0h required 0",
               {ack_o, start_o, busy_o, hum_o, tmp_o, valid_o, update_o, fail_o, err_cnt_o});
    end
    wait_start(30, t1);
    checks++;
    if (t1 - tr !== 11) begin
      fails++; $display("[TB] FAIL reset_first_start: got %0d cycles required 11", t1 - tr);
    end
  endtask

  task automatic test_periodic;
    int tr, t1, t2, t3;
    do_reset(tr);
    wait_start(30, t1);
    checks++;
    if (ack_o !== 1'b0) begin
      fails++; $display("[TB] FAIL periodic_ack: got %0b required 0", ack_o);
    end
    engine_reply(1'b1, 1'b0, GOOD_FRAME);
    checks++;
    if (update_o !== 1'b0) begin
      fails++; $display("[TB] FAIL good_update_early: got %0b required 0", update_o);
    end
    @(negedge clk);
    checks++;
    if (update_o !== 1'b1) begin
      fails++; $display("[TB] FAIL good_update: got %0b required 1", update_o);
    end
    checks++;
    if ({hum_o, tmp_o, valid_o, fail_o} !== {16'h3700, 16'h1A00, 1'b1, 1'b0}) begin
      fails++;
      $display("[TB] FAIL good_latch: got hum %0h tmp %0h valid %0b fail %0b required 3700 1a00 1 0",
               hum_o, tmp_o, valid_o, fail_o);
    end
    wait_start(40, t2);
    checks++;
    if (t2 - t1 !== 20 || ack_o !== 1'b0) begin
      fails++; $display("[TB] FAIL poll_period1: got %0d ack %0b required 20 ack 0", t2 - t1, ack_o);
    end
    engine_reply(1'b1, 1'b0, GOOD_FRAME);
    wait_start(40, t3);
    checks++;
    if (t3 - t2 !== 20) begin
      fails++; $display("[TB] FAIL poll_period2: got %0d required 20", t3 - t2);
    end
  endtask

  task automatic test_bad_checksum;
    int tr, t1, t2, t3;
    logic seen_upd;
    do_reset(tr);
    wait_start(30, t1);
    engine_reply(1'b1, 1'b0, GOOD_FRAME);
    wait_start(40, t2);
    engine_reply(1'b1, 1'b0, BAD_FRAME);
    seen_upd = update_o;
    repeat (3) begin
      @(negedge clk);
      seen_upd = seen_upd | update_o;
    end
    checks++;
    if (seen_upd !== 1'b0) begin
      fails++; $display("[TB] FAIL badchk_update: got %0b required 0", seen_upd);
    end
    checks++;
    if (err_cnt_o !== 8'd1) begin
      fails++; $display("[TB] FAIL badchk_errcnt: got %0d required 1", err_cnt_o);
    end
    wait_start(40, t3);
    checks++;
    if (t3 - t2 !== 11) begin
      fails++; $display("[TB] FAIL badchk_retry_gap: got %0d required 11", t3 - t2);
    end
    checks++;
    if ({hum_o, tmp_o} !== {16'h3700, 16'h1A00}) begin
      fails++; $display("[TB] FAIL badchk_hold: got %0h %0h required 3700 1a00", hum_o, tmp_o);
    end
  endtask

  task automatic test_timeout;
    int tr, t1, t2, t3, t4, nb;
    do_reset(tr);
    wait_start(30, t1);
    count_busy(nb);
    checks++;
    if (nb !== 5) begin
      fails++; $display("[TB] FAIL tout_busy1: got %0d required 5", nb);
    end
    wait_start(40, t2);
    checks++;
    if (t2 - t1 !== 11 || err_cnt_o !== 8'd1 || fail_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL tout_retry1: got gap %0d err %0d fail %0b required 11 1 0",
               t2 - t1, err_cnt_o, fail_o);
    end
    count_busy(nb);
    checks++;
    if (nb !== 5) begin
      fails++; $display("[TB] FAIL tout_busy2: got %0d required 5", nb);
    end
    wait_start(40, t3);
    checks++;
    if (t3 - t2 !== 11) begin
      fails++; $display("[TB] FAIL tout_retry2: got gap %0d required 11", t3 - t2);
    end
    count_busy(nb);
    wait_start(40, t4);
    checks++;
    if (t4 - t3 !== 20 || err_cnt_o !== 8'd3 || fail_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL tout_exhaust: got gap %0d err %0d fail %0b required 20 3 1",
               t4 - t3, err_cnt_o, fail_o);
    end
    engine_reply(1'b1, 1'b0, GOOD_FRAME);
    @(negedge clk);
    checks++;
    if (fail_o !== 1'b0 || err_cnt_o !== 8'd3 || update_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL tout_recover: got fail %0b err %0d upd %0b required 0 3 1",
               fail_o, err_cnt_o, update_o);
    end
  endtask

  task automatic test_request;
    int tr, t1, t2;
    logic seen_upd;
    do_reset(tr);
    wait_start(30, t1);
    engine_reply(1'b1, 1'b0, GOOD_FRAME);
    @(negedge clk);
    req_i = 1'b1;
    wait_start(30, t2);
    checks++;
    if (t2 - t1 !== 11 || ack_o !== 1'b1) begin
      fails++; $display("[TB] FAIL req_start: got gap %0d ack %0b required 11 1", t2 - t1, ack_o);
    end
    req_i = 1'b0;
    engine_reply(1'b1, 1'b1, GOOD_FRAME);
    seen_upd = update_o;
    repeat (3) begin
      @(negedge clk);
      seen_upd = seen_upd | update_o;
    end
    checks++;
    if (seen_upd !== 1'b0 || err_cnt_o !== 8'd1 || hum_o !== 16'h3700) begin
      fails++;
      $display("[TB] FAIL done_err_same: got upd %0b err %0d hum %0h required 0 1 3700",
               seen_upd, err_cnt_o, hum_o);
    end
  endtask

  task automatic test_reset_busy;
    int tr, t1, t2, t3;
    do_reset(tr);
    wait_start(30, t1);
    engine_reply(1'b1, 1'b0, GOOD_FRAME);
    wait_start(40, t2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({ack_o, start_o, busy_o, hum_o, tmp_o, valid_o, update_o, fail_o, err_cnt_o} !== '0) begin
      fails++;
      $display("[TB] FAIL rst_busy_outputs: got %0h required 0",
               {ack_o, start_o, busy_o, hum_o, tmp_o, valid_o, update_o, fail_o, err_cnt_o});
    end
    @(negedge clk);
    rst = 1'b1; en = 1'b1;
    tr = cyc;
    engine_reply(1'b1, 1'b0, GOOD_FRAME);
    wait_start(30, t3);
    checks++;
    if (t3 - tr !== 11 || valid_o !== 1'b0 || hum_o !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL rst_busy_after: got gap %0d valid %0b hum %0h required 11 0 0",
               t3 - tr, valid_o, hum_o);
    end
  endtask

  initial begin
    test_reset;
    test_periodic;
    test_bad_checksum;
    test_timeout;
    test_request;
    test_reset_busy;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
